cv32e40s_instr_obi_arbiter: RTL and testbench
=============================================

Name: cv32e40s_instr_obi_arbiter

Overview:
- Shares the single instruction-side OBI transaction interface (trans_*/resp_*) between two requesters.
  - Requester A: prefetcher, sequential fetch.
  - Requester B: pointer/vector fetch, e.g. CLIC or table-jump pointer.
- Arbitrates the address phase and limits outstanding transactions to MAX_OUTSTANDING.
- Records the requester ID of each granted transaction in an in-order ID FIFO, and routes each response back to the requester that issued it.
- Supports per-requester kill, which silently discards that requester's in-flight responses.

Parameters:
- MAX_OUTSTANDING, 2, maximum granted-but-unanswered transactions (legal 1..8); sets ID FIFO depth.
- CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived, not overridden).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- a_valid_i  in  1  requester A transaction valid
- a_ready_o  out  1  requester A transaction accepted this cycle
- a_trans_i  in  obi_inst_req_t  requester A payload
- a_kill_i  in  1  discard all in-flight A responses; block new A grant this cycle
- a_resp_valid_o  out  1  response valid to A
- b_valid_i  in  1  requester B transaction valid
- b_ready_o  out  1  requester B transaction accepted this cycle
- b_trans_i  in  obi_inst_req_t  requester B payload
- b_kill_i  in  1  same as a_kill_i, for B
- b_resp_valid_o  out  1  response valid to B
- resp_o  out  obi_inst_resp_t  response payload, shared by A and B (qualified by a_/b_resp_valid_o)
- trans_valid_o  out  1  transaction valid to OBI interface
- trans_ready_i  in  1  OBI interface ready
- trans_o  out  obi_inst_req_t  selected payload
- resp_valid_i  in  1  response valid from OBI interface
- resp_i  in  obi_inst_resp_t  response payload
- outstanding_cnt_o  out  CNT_W  current outstanding count
- protocol_err_o  out  1  response received with no outstanding entry

Behaviour:
- Reset values (async, all registers): lock_q=0, lock_id_q=A, cnt=0, FIFO pointers 0, all drop bits 0.
  - Combinational outputs at reset: trans_valid_o=0, a_ready_o=b_ready_o=0, a_resp_valid_o=b_resp_valid_o=0, protocol_err_o=0.
- Eligibility:
  - elig_a = a_valid_i && !a_kill_i.
  - elig_b = b_valid_i && !b_kill_i.
  - full = (cnt == MAX_OUTSTANDING).
- Arbitration (unlocked): fixed priority, B over A.
  - sel = B if elig_b, else A if elig_a, else none.
- Lock FSM, states UNLOCKED and LOCKED:
  - UNLOCKED -> LOCKED when trans_valid_o && !trans_ready_i; lock_id_q <= sel.
  - LOCKED -> UNLOCKED when trans_ready_i.
  - While LOCKED:
    - trans_valid_o=1 and sel=lock_id_q, regardless of the other requester or of kill.
    - The locked requester must hold valid and payload stable.
    - A kill during LOCKED does not retract the request; the transaction, once accepted, is pushed with drop=1.
- trans_valid_o = !full && (LOCKED || elig_a || elig_b); trans_o = payload of sel.
  - cnt cannot rise while LOCKED, so full cannot newly assert during a lock.
- Acceptance: acc = trans_valid_o && trans_ready_i.
  - a_ready_o = acc && sel==A; b_ready_o = acc && sel==B.
  - 0-cycle handshake: ready is combinational on trans_ready_i.
- Push on acc: FIFO[wptr] <= {id=sel, drop=kill of sel in same cycle}; wptr wraps at MAX_OUTSTANDING-1 -> 0.
- Pop: pop = resp_valid_i && cnt!=0; rptr wraps likewise.
  - Head entry not dropped: resp_o=resp_i; assert a_resp_valid_o or b_resp_valid_o per head id, same cycle (0 latency).
  - Head entry dropped, or its requester's kill is asserted this cycle: response consumed, no resp_valid output.
- Kill: x_kill_i sets drop=1 on every valid FIFO entry with id==x, effective from the next cycle. Same-cycle pop and push are covered by the rules above.
- Counter:
  - cnt += acc − pop; simultaneous acc and pop leaves it unchanged.
  - Never exceeds MAX_OUTSTANDING; never underflows.
  - outstanding_cnt_o = cnt.
- protocol_err_o = resp_valid_i && cnt==0. Single-cycle, combinational; the response is ignored and no resp_valid is output.
- Responses are strictly in order. A and B responses interleave exactly per grant order.

Test Plan:
- Both valid from idle, trans_ready_i=1 -> B granted (b_ready_o=1, a_ready_o=0); A granted next cycle; responses R1,R2 -> b_resp_valid_o then a_resp_valid_o; cnt 0->1->2->1->0.
- A valid, trans_ready_i=0 for 3 cycles, B asserts in cycle 2 -> trans_o stays A payload, LOCKED; A accepted on cycle 4; B granted on cycle 5.
- MAX_OUTSTANDING=2, two A grants, no responses -> trans_valid_o=0, cnt=2. One response -> cnt=1 and trans_valid_o reasserts next cycle. Push+pop in same cycle -> cnt stays 1.
- Two A grants outstanding, pulse a_kill_i, then 2 responses -> a_resp_valid_o never asserts, cnt reaches 0. A B grant issued after the kill still returns b_resp_valid_o.
- Kill asserted while A is LOCKED, then trans_ready_i=1 -> entry pushed with drop=1; its response is discarded.
- resp_valid_i=1 with cnt=0 -> protocol_err_o=1 for 1 cycle, no resp_valid outputs, cnt stays 0. Assert rst_n low mid-transfer -> all outputs 0 and cnt=0 immediately.

Source files
------------

// File: rtl/cv32e40s_instr_obi_arbiter_if.sv
// Instruction-side OBI payload types and the arbiter's bundled port interface.
// The slave modport is the arbiter's view; master is the surrounding environment.
package cv32e40s_instr_obi_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic        dbg;
  } obi_inst_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_inst_resp_t;
endpackage

interface cv32e40s_instr_obi_arbiter_if #(
  parameter int unsigned MAX_OUTSTANDING = 2
);
  import cv32e40s_instr_obi_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic           a_valid_i;
  logic           a_ready_o;
  obi_inst_req_t  a_trans_i;
  logic           a_kill_i;
  logic           a_resp_valid_o;
  logic           b_valid_i;
  logic           b_ready_o;
  obi_inst_req_t  b_trans_i;
  logic           b_kill_i;
  logic           b_resp_valid_o;
  obi_inst_resp_t resp_o;
  logic           trans_valid_o;
  logic           trans_ready_i;
  obi_inst_req_t  trans_o;
  logic           resp_valid_i;
  obi_inst_resp_t resp_i;
  logic [CNT_W-1:0] outstanding_cnt_o;
  logic           protocol_err_o;

  modport slave (
    input  a_valid_i, a_trans_i, a_kill_i,
    input  b_valid_i, b_trans_i, b_kill_i,
    input  trans_ready_i, resp_valid_i, resp_i,
    output a_ready_o, a_resp_valid_o, b_ready_o, b_resp_valid_o,
    output resp_o, trans_valid_o, trans_o, outstanding_cnt_o, protocol_err_o
  );

  modport master (
    output a_valid_i, a_trans_i, a_kill_i,
    output b_valid_i, b_trans_i, b_kill_i,
    output trans_ready_i, resp_valid_i, resp_i,
    input  a_ready_o, a_resp_valid_o, b_ready_o, b_resp_valid_o,
    input  resp_o, trans_valid_o, trans_o, outstanding_cnt_o, protocol_err_o
  );
endinterface

// File: rtl/cv32e40s_instr_obi_arbiter.sv
// Two-requester arbiter for the instruction OBI port: B-over-A priority, address-phase
// lock, outstanding limit, in-order ID FIFO for response routing and per-requester kill.
//
// state    | meaning
// UNLOCKED | free arbitration, B over A
// LOCKED   | request offered but not accepted; hold the same requester until ready
module cv32e40s_instr_obi_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic                         clk,
  input logic                         rst_n,
  cv32e40s_instr_obi_arbiter_if.slave bus
);
  import cv32e40s_instr_obi_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic        ID_A  = 1'b0;
  localparam logic        ID_B  = 1'b1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  lock_state_e r_state;
  lock_state_e w_state_nxt;
  logic        r_lock_id;
  logic        w_lock_id_nxt;

  logic [CNT_W-1:0]           r_cnt;
  logic [PTR_W-1:0]           r_wptr;
  logic [PTR_W-1:0]           r_rptr;
  logic [MAX_OUTSTANDING-1:0] r_fifo_id;
  logic [MAX_OUTSTANDING-1:0] r_fifo_drop;
  logic [MAX_OUTSTANDING-1:0] r_fifo_vld;

  logic w_elig_a;
  logic w_elig_b;
  logic w_full;
  logic w_sel_id;
  logic w_sel_kill;
  logic w_trans_valid;
  logic w_acc;
  logic w_pop;
  logic w_head_id;
  logic w_head_drop;
  logic w_head_kill;
  logic w_deliver;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_elig_a = bus.a_valid_i && !bus.a_kill_i;
  assign w_elig_b = bus.b_valid_i && !bus.b_kill_i;
  assign w_full   = (r_cnt == CNT_MAX);

  always_comb begin
    w_sel_id = ID_A;
    if (r_state == LOCKED) begin
      w_sel_id = r_lock_id;
    end else if (w_elig_b) begin
      w_sel_id = ID_B;
    end
  end

  // A locked request stays offered even if its requester is killed meanwhile.
  assign w_trans_valid = !w_full && ((r_state == LOCKED) || w_elig_a || w_elig_b);
  assign w_acc         = w_trans_valid && bus.trans_ready_i;
  assign w_sel_kill    = (w_sel_id == ID_B) ? bus.b_kill_i : bus.a_kill_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_lock_id_nxt = r_lock_id;
    if (r_state == UNLOCKED) begin
      if (w_trans_valid && !bus.trans_ready_i) begin
        w_state_nxt   = LOCKED;
        w_lock_id_nxt = w_sel_id;
      end
    end else begin
      if (bus.trans_ready_i) begin
        w_state_nxt = UNLOCKED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= UNLOCKED;
      r_lock_id <= ID_A;
    end else begin
      r_state   <= w_state_nxt;
      r_lock_id <= w_lock_id_nxt;
    end
  end

  assign w_pop       = bus.resp_valid_i && (r_cnt != '0);
  assign w_head_id   = r_fifo_id[r_rptr];
  assign w_head_drop = r_fifo_drop[r_rptr];
  assign w_head_kill = (w_head_id == ID_B) ? bus.b_kill_i : bus.a_kill_i;
  assign w_deliver   = w_pop && !w_head_drop && !w_head_kill;

  // Push and pop never address the same slot: push needs !full, pop needs cnt!=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fifo_id   <= '0;
      r_fifo_drop <= '0;
      r_fifo_vld  <= '0;
    end else begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        if (r_fifo_vld[i] && ((bus.a_kill_i && (r_fifo_id[i] == ID_A)) ||
                              (bus.b_kill_i && (r_fifo_id[i] == ID_B)))) begin
          r_fifo_drop[i] <= 1'b1;
        end
      end
      if (w_acc) begin
        r_fifo_id[r_wptr]   <= w_sel_id;
        r_fifo_drop[r_wptr] <= w_sel_kill;
        r_fifo_vld[r_wptr]  <= 1'b1;
        r_wptr              <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_fifo_vld[r_rptr] <= 1'b0;
        r_rptr             <= ptr_inc(r_rptr);
      end
      r_cnt <= r_cnt + CNT_W'(w_acc) - CNT_W'(w_pop);
    end
  end

  assign bus.trans_valid_o     = w_trans_valid;
  assign bus.trans_o           = (w_sel_id == ID_B) ? bus.b_trans_i : bus.a_trans_i;
  assign bus.a_ready_o         = w_acc && (w_sel_id == ID_A);
  assign bus.b_ready_o         = w_acc && (w_sel_id == ID_B);
  assign bus.resp_o            = bus.resp_i;
  assign bus.a_resp_valid_o    = w_deliver && (w_head_id == ID_A);
  assign bus.b_resp_valid_o    = w_deliver && (w_head_id == ID_B);
  assign bus.outstanding_cnt_o = r_cnt;
  assign bus.protocol_err_o    = bus.resp_valid_i && (r_cnt == '0);

endmodule

// File: tb/tb_cv32e40s_instr_obi_arbiter.sv
// Directed bench for the instruction OBI arbiter; a grant-order scoreboard predicts
// which requester each response is routed to and whether it is discarded.
module tb_cv32e40s_instr_obi_arbiter;
  import cv32e40s_instr_obi_pkg::*;

  localparam int unsigned MAXO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cv32e40s_instr_obi_arbiter_if #(.MAX_OUTSTANDING(MAXO)) bus ();

  cv32e40s_instr_obi_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic id;
    logic drop;
  } sb_t;

  sb_t sb_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.a_valid_i     = 1'b0;
    bus.a_trans_i     = '0;
    bus.a_kill_i      = 1'b0;
    bus.b_valid_i     = 1'b0;
    bus.b_trans_i     = '0;
    bus.b_kill_i      = 1'b0;
    bus.trans_ready_i = 1'b0;
    bus.resp_valid_i  = 1'b0;
    bus.resp_i        = '0;
  endtask

  task automatic set_resp(input logic [31:0] data);
    bus.resp_valid_i = 1'b1;
    bus.resp_i.rdata = data;
    bus.resp_i.err   = 1'b0;
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, 64'(bus.outstanding_cnt_o), 64'(sb_q.size()));
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_tv"},  64'(bus.trans_valid_o),  64'd0);
    chk({tag, "_ra"},  64'(bus.a_ready_o),      64'd0);
    chk({tag, "_rb"},  64'(bus.b_ready_o),      64'd0);
    chk({tag, "_arv"}, 64'(bus.a_resp_valid_o), 64'd0);
    chk({tag, "_brv"}, 64'(bus.b_resp_valid_o), 64'd0);
    chk({tag, "_err"}, 64'(bus.protocol_err_o), 64'd0);
    chk({tag, "_cnt"}, 64'(bus.outstanding_cnt_o), 64'd0);
  endtask

  // Expect requester id to be accepted this cycle; record it in grant order.
  task automatic grant(input logic id, input string tag);
    logic [31:0] exp_addr;
    sb_t         e;
    exp_addr = id ? bus.b_trans_i.addr : bus.a_trans_i.addr;
    chk({tag, "_tv"},   64'(bus.trans_valid_o), 64'd1);
    chk({tag, "_ra"},   64'(bus.a_ready_o),     64'(id == 1'b0));
    chk({tag, "_rb"},   64'(bus.b_ready_o),     64'(id == 1'b1));
    chk({tag, "_addr"}, 64'(bus.trans_o.addr),  64'(exp_addr));
    e.id   = id;
    e.drop = id ? bus.b_kill_i : bus.a_kill_i;
    sb_q.push_back(e);
  endtask

  // Response currently driven: route it against the oldest recorded grant.
  task automatic resp(input string tag);
    sb_t  e;
    logic k;
    logic dlv;
    if (sb_q.size() == 0) begin
      chk({tag, "_err"}, 64'(bus.protocol_err_o), 64'd1);
      chk({tag, "_arv"}, 64'(bus.a_resp_valid_o), 64'd0);
      chk({tag, "_brv"}, 64'(bus.b_resp_valid_o), 64'd0);
    end else begin
      e   = sb_q.pop_front();
      k   = e.id ? bus.b_kill_i : bus.a_kill_i;
      dlv = !e.drop && !k;
      chk({tag, "_err"}, 64'(bus.protocol_err_o), 64'd0);
      chk({tag, "_arv"}, 64'(bus.a_resp_valid_o), 64'(dlv && (e.id == 1'b0)));
      chk({tag, "_brv"}, 64'(bus.b_resp_valid_o), 64'(dlv && (e.id == 1'b1)));
      if (dlv) chk({tag, "_data"}, 64'(bus.resp_o.rdata), 64'(bus.resp_i.rdata));
    end
  endtask

  task automatic kill_model(input logic id);
    foreach (sb_q[i]) if (sb_q[i].id == id) sb_q[i].drop = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    #1;
    chk_idle_outs("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_idle_outs("post_rst");

    // Both valid from idle: B first, then A; responses routed in grant order.
    bus.a_valid_i = 1'b1; bus.a_trans_i = '{addr: 32'hA000_0010, prot: 3'b100, dbg: 1'b0};
    bus.b_valid_i = 1'b1; bus.b_trans_i = '{addr: 32'hB000_0020, prot: 3'b100, dbg: 1'b0};
    bus.trans_ready_i = 1'b1;
    #1; grant(1'b1, "t1_b"); tick(); chk_cnt("t1_cnt1");
    bus.b_valid_i = 1'b0;
    #1; grant(1'b0, "t1_a"); tick(); chk_cnt("t1_cnt2");
    bus.a_valid_i = 1'b0; set_resp(32'h1111_0001);
    #1; resp("t1_r1"); tick(); chk_cnt("t1_cnt3");
    set_resp(32'h2222_0002);
    #1; resp("t1_r2"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t1_cnt4");

    // Lock: A stalled, B arriving later must not steal the address phase.
    bus.trans_ready_i = 1'b0;
    bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_0030;
    #1; chk("t2_tv0", 64'(bus.trans_valid_o), 64'd1); chk("t2_ra0", 64'(bus.a_ready_o), 64'd0);
    tick();
    bus.b_valid_i = 1'b1; bus.b_trans_i.addr = 32'hB000_0040;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("t2_lk_addr", 64'(bus.trans_o.addr), 64'h0000_0000_A000_0030);
      chk("t2_lk_rb",   64'(bus.b_ready_o),    64'd0);
      tick();
    end
    bus.trans_ready_i = 1'b1;
    #1; grant(1'b0, "t2_a"); tick();
    bus.a_valid_i = 1'b0;
    #1; grant(1'b1, "t2_b"); tick();
    bus.b_valid_i = 1'b0; set_resp(32'h3333_0003);
    #1; resp("t2_r1"); tick();
    set_resp(32'h4444_0004);
    #1; resp("t2_r2"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t2_cnt");

    // Outstanding limit, then push and pop in the same cycle.
    bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_0050;
    #1; grant(1'b0, "t3_g1"); tick();
    bus.a_trans_i.addr = 32'hA000_0054;
    #1; grant(1'b0, "t3_g2"); tick(); chk_cnt("t3_full_cnt");
    bus.a_trans_i.addr = 32'hA000_0058;
    #1; chk("t3_full_tv", 64'(bus.trans_valid_o), 64'd0); chk("t3_full_ra", 64'(bus.a_ready_o), 64'd0);
    set_resp(32'h5555_0005);
    #1; resp("t3_r1"); chk("t3_full_tv2", 64'(bus.trans_valid_o), 64'd0); tick(); chk_cnt("t3_cnt1");
    set_resp(32'h6666_0006);
    #1; resp("t3_r2"); grant(1'b0, "t3_pp"); tick(); chk_cnt("t3_cnt_pp");
    bus.a_valid_i = 1'b0; set_resp(32'h7777_0007);
    #1; resp("t3_r3"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t3_cnt0");

    // Kill two in-flight A grants; a later B grant still gets its response.
    bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_0060;
    #1; grant(1'b0, "t4_g1"); tick();
    bus.a_trans_i.addr = 32'hA000_0064;
    #1; grant(1'b0, "t4_g2"); tick();
    bus.a_valid_i = 1'b0; bus.a_kill_i = 1'b1;
    #1; kill_model(1'b0); tick();
    bus.a_kill_i = 1'b0; set_resp(32'h8888_0008);
    #1; resp("t4_r1"); tick();
    bus.b_valid_i = 1'b1; bus.b_trans_i.addr = 32'hB000_0070; set_resp(32'h9999_0009);
    #1; resp("t4_r2"); grant(1'b1, "t4_b"); tick();
    bus.b_valid_i = 1'b0; set_resp(32'hAAAA_000A);
    #1; resp("t4_r3"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t4_cnt");

    // Kill while A is locked: accepted anyway, response discarded.
    bus.trans_ready_i = 1'b0; bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_0080;
    #1; tick();
    bus.a_kill_i = 1'b1;
    #1; chk("t5_lk_tv", 64'(bus.trans_valid_o), 64'd1); chk("t5_lk_ra", 64'(bus.a_ready_o), 64'd0);
    tick();
    bus.trans_ready_i = 1'b1;
    #1; grant(1'b0, "t5_g"); kill_model(1'b0); tick();
    bus.a_valid_i = 1'b0; bus.a_kill_i = 1'b0; set_resp(32'hBBBB_000B);
    #1; resp("t5_r"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t5_cnt");

    // Kill in the same cycle as the response pop.
    bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_0090;
    #1; grant(1'b0, "t5k_g"); tick();
    bus.a_valid_i = 1'b0; bus.a_kill_i = 1'b1; set_resp(32'hCCCC_000C);
    #1; resp("t5k_r"); kill_model(1'b0); tick();
    bus.a_kill_i = 1'b0; bus.resp_valid_i = 1'b0; chk_cnt("t5k_cnt");

    // Response with nothing outstanding.
    set_resp(32'hDDDD_000D);
    #1; resp("t6_perr"); tick(); chk_cnt("t6_cnt");
    bus.resp_valid_i = 1'b0;
    #1; chk("t6_err_clr", 64'(bus.protocol_err_o), 64'd0);

    // Reset mid-transfer with one outstanding and A locked.
    bus.a_valid_i = 1'b1; bus.a_trans_i.addr = 32'hA000_00A0;
    #1; grant(1'b0, "t7_g"); tick();
    bus.trans_ready_i = 1'b0;
    #1; tick();
    rst_n = 1'b0; bus.a_valid_i = 1'b0; sb_q.delete();
    #1; chk_idle_outs("t7_rst");
    tick();
    rst_n = 1'b1;
    #1; chk("t7_unlocked_tv", 64'(bus.trans_valid_o), 64'd0);
    tick();
    bus.b_valid_i = 1'b1; bus.b_trans_i.addr = 32'hB000_00B0; bus.trans_ready_i = 1'b1;
    #1; grant(1'b1, "t7_b"); tick();
    bus.b_valid_i = 1'b0; set_resp(32'hEEEE_000E);
    #1; resp("t7_r"); tick(); bus.resp_valid_i = 1'b0; chk_cnt("t7_cnt");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
